// File: rtl/definitions.sv
// Shared fetch/control definitions: fetch FSM states, default widths, halt
// encoding and the opcode map decoded by the control FSM.
package definitions;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;

  localparam logic [INSTR_W-1:0] HALT_WORD = 9'h1FF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALTED
  } fetch_state_t;

  // Opcode occupies the top three bits of every instruction word.
  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] XOR = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] RSL = 3'b011;
  localparam logic [2:0] MOV = 3'b100;
  localparam logic [2:0] LD  = 3'b101;
  localparam logic [2:0] ST  = 3'b110;
  localparam logic [2:0] BR  = 3'b111;

endpackage

// File: rtl/program_counter.sv
// Program counter register: load beats increment, increment wraps modulo 2^PC_W.
// Updates one cycle after load/inc; never stalls.
module program_counter #(
  parameter int PC_W     = 8,
  parameter int START_PC = 0
) (
  input  logic            clock,
  input  logic            resetN,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc <= PC_W'(START_PC);
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, strobes instruction memory, holds the word for control.
// start->imemReq 1 cycle, imemValid->insValid 1 cycle; held until nextIns consumes it.
module fetch_unit #(
  parameter int                 PC_W      = definitions::PC_W,
  parameter int                 INSTR_W   = definitions::INSTR_W,
  parameter logic [INSTR_W-1:0] HALT_WORD = definitions::HALT_WORD,
  parameter int                 START_PC  = 0
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               start,
  input  logic               nextIns,
  input  logic               branchTaken,
  input  logic [PC_W-1:0]    branchTarget,
  output logic               imemReq,
  output logic [PC_W-1:0]    imemAddr,
  input  logic [INSTR_W-1:0] imemData,
  input  logic               imemValid,
  output logic [2:0]         instructions,
  output logic [INSTR_W-4:0] operand,
  output logic               insValid,
  output logic [PC_W-1:0]    pc,
  output logic               done,
  output logic               seqErr
);

  import definitions::*;

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic [INSTR_W-1:0] ir;
  logic               advance;
  logic               capture;

  assign advance = (state == HOLD) && nextIns;
  assign capture = (state == WAIT) && imemValid && (imemData != HALT_WORD);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT: begin
        if (imemValid) begin
          state_nxt = (imemData == HALT_WORD) ? HALTED : HOLD;
        end
      end
      HOLD:    if (nextIns) state_nxt = REQ;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // Responses outside WAIT (stale after reset, or spurious) never touch IR.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ir <= '0;
    end else if (capture) begin
      ir <= imemData;
    end
  end

  // An advance request is only legal while an instruction is held; HALTED ignores it.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      seqErr <= 1'b0;
    end else if (nextIns && (state == IDLE || state == REQ || state == WAIT)) begin
      seqErr <= 1'b1;
    end
  end

  program_counter #(
    .PC_W    (PC_W),
    .START_PC(START_PC)
  ) u_program_counter (
    .clock (clock),
    .resetN(resetN),
    .load  (advance && branchTaken),
    .inc   (advance && !branchTaken),
    .target(branchTarget),
    .pc    (pc)
  );

  assign imemReq      = (state == REQ);
  assign imemAddr     = pc;
  assign insValid     = (state == HOLD);
  assign done         = (state == HALTED);
  assign instructions = ir[INSTR_W-1 -: 3];
  assign operand      = ir[INSTR_W-4:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized episodes against a
// transaction-level model with a randomized-latency instruction memory.
module tb_fetch_unit;

  logic       clock = 1'b0;
  logic       resetN;
  logic       start;
  logic       nextIns;
  logic       branchTaken;
  logic [7:0] branchTarget;
  logic       imemReq;
  logic [7:0] imemAddr;
  logic [8:0] imemData;
  logic       imemValid;
  logic [2:0] instructions;
  logic [5:0] operand;
  logic       insValid;
  logic [7:0] pc;
  logic       done;
  logic       seqErr;

  fetch_unit dut (
    .clock       (clock),
    .resetN      (resetN),
    .start       (start),
    .nextIns     (nextIns),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemData    (imemData),
    .imemValid   (imemValid),
    .instructions(instructions),
    .operand     (operand),
    .insValid    (insValid),
    .pc          (pc),
    .done        (done),
    .seqErr      (seqErr)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference: phase 0 idle, 1 request, 2 awaiting data, 3 holding, 4 halted.
  int         m_ph;
  logic [7:0] m_pc;
  logic [8:0] m_ir;
  logic       m_seq;

  logic [8:0] mem [256];
  int         pend_cnt;
  logic [7:0] pend_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imemReq"},  32'(imemReq),      32'(m_ph == 1));
    check({tag, ".imemAddr"}, 32'(imemAddr),     32'(m_pc));
    check({tag, ".insValid"}, 32'(insValid),     32'(m_ph == 3));
    check({tag, ".opcode"},   32'(instructions), 32'(m_ir[8:6]));
    check({tag, ".operand"},  32'(operand),      32'(m_ir[5:0]));
    check({tag, ".pc"},       32'(pc),           32'(m_pc));
    check({tag, ".done"},     32'(done),         32'(m_ph == 4));
    check({tag, ".seqErr"},   32'(seqErr),       32'(m_seq));
  endtask

  task automatic model_reset();
    m_ph  = 0;
    m_pc  = 8'h00;
    m_ir  = 9'h000;
    m_seq = 1'b0;
  endtask

  // Entered and left on a falling edge; reset is checked while still asserted.
  task automatic do_reset(input string tag);
    resetN = 1'b0;
    start = 1'b0; nextIns = 1'b0; branchTaken = 1'b0; branchTarget = 8'h00;
    imemValid = 1'b0; imemData = 9'h000;
    pend_cnt = 0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clock);
    resetN = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model by the rules, check next cycle.
  task automatic step(input string tag, input logic st, input logic ni, input logic bt,
                      input logic [7:0] tg, input logic v, input logic [8:0] d);
    start = st; nextIns = ni; branchTaken = bt; branchTarget = tg;
    imemValid = v; imemData = d;
    case (m_ph)
      0: begin
        if (ni) m_seq = 1'b1;
        if (st) m_ph = 1;
      end
      1: begin
        if (ni) m_seq = 1'b1;
        m_ph = 2;
      end
      2: begin
        if (ni) m_seq = 1'b1;
        if (v) begin
          if (d == 9'h1FF) m_ph = 4;
          else begin
            m_ir = d;
            m_ph = 3;
          end
        end
      end
      3: begin
        if (ni) begin
          m_pc = bt ? tg : m_pc + 8'd1;
          m_ph = 1;
        end
      end
      default: ;
    endcase
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic rand_cycle();
    logic       st, ni, bt, v;
    logic [7:0] tg;
    logic [8:0] d;
    st = ($urandom_range(0, 3) == 0);
    ni = (m_ph == 3) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
    bt = 1'($urandom_range(0, 1));
    tg = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    v  = 1'b0;
    d  = 9'($urandom);
    if (m_ph == 1) begin
      pend_addr = m_pc;
      pend_cnt  = $urandom_range(1, 3);
    end else if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        v = 1'b1;
        d = mem[pend_addr];
      end
    end else if ($urandom_range(0, 9) == 0) begin
      v = 1'b1;
    end
    step("rnd", st, ni, bt, tg, v, d);
  endtask

  initial begin
    resetN = 1'b1;
    start = 1'b0; nextIns = 1'b0; branchTaken = 1'b0; branchTarget = 8'h00;
    imemValid = 1'b0; imemData = 9'h000;
    pend_cnt = 0; pend_addr = 8'h00;
    model_reset();
    @(negedge clock);

    // First fetch at address 0, data two cycles after the request.
    do_reset("rst0");
    step("start", 1, 0, 0, 8'h00, 0, 9'h000);
    check("start.req_const", 32'(imemReq), 32'd1);
    step("req", 0, 0, 0, 8'h00, 0, 9'h000);
    step("wait", 0, 0, 0, 8'h00, 0, 9'h000);
    step("data041", 0, 0, 0, 8'h00, 1, 9'h041);
    check("hold.opcode_const", 32'(instructions), 32'd1);
    check("hold.operand_const", 32'(operand), 32'h01);

    // Branch to 5, then sequential advance to 6.
    step("br5", 0, 1, 1, 8'h05, 0, 9'h000);
    step("br5.req", 0, 0, 0, 8'h00, 0, 9'h000);
    step("br5.data", 0, 0, 0, 8'h00, 1, 9'h0AA);
    step("seq6", 0, 1, 0, 8'h99, 0, 9'h000);
    check("seq6.addr_const", 32'(imemAddr), 32'd6);
    step("seq6.req", 0, 0, 0, 8'h00, 0, 9'h000);
    step("seq6.data", 0, 0, 0, 8'h00, 1, 9'h123);

    // branchTaken alone is inert; with nextIns it jumps to 0x20.
    step("bt_only", 0, 0, 1, 8'h20, 0, 9'h000);
    check("bt_only.pc_const", 32'(pc), 32'd6);
    step("br20", 0, 1, 1, 8'h20, 0, 9'h000);
    check("br20.addr_const", 32'(imemAddr), 32'h20);
    step("br20.req", 0, 0, 0, 8'h00, 0, 9'h000);
    step("br20.data", 0, 0, 0, 8'h00, 1, 9'h0D5);

    // Wrap from 0xFF to 0x00, then fetch the halt word.
    step("brFF", 0, 1, 1, 8'hFF, 0, 9'h000);
    step("brFF.req", 0, 0, 0, 8'h00, 0, 9'h000);
    step("brFF.data", 0, 0, 0, 8'h00, 1, 9'h002);
    step("wrap", 0, 1, 0, 8'h00, 0, 9'h000);
    check("wrap.addr_const", 32'(imemAddr), 32'd0);
    step("wrap.req", 0, 0, 0, 8'h00, 0, 9'h000);
    step("halt", 0, 0, 0, 8'h00, 1, 9'h1FF);
    check("halt.done_const", 32'(done), 32'd1);
    for (int i = 0; i < 4; i++) step("halted", 1, 1, 1, 8'h33, 1, 9'h041);
    check("halted.seqErr_const", 32'(seqErr), 32'd0);

    // Reset while a fetch is outstanding; the late response must be dropped.
    do_reset("rst1");
    step("mid.start", 1, 0, 0, 8'h00, 0, 9'h000);
    step("mid.req", 0, 0, 0, 8'h00, 0, 9'h000);
    do_reset("mid.rst");
    step("mid.late", 0, 0, 0, 8'h00, 1, 9'h041);
    check("mid.insValid_const", 32'(insValid), 32'd0);
    for (int i = 0; i < 3; i++) step("mid.idle", 0, 0, 0, 8'h00, 0, 9'h000);

    // nextIns during WAIT: sticky error, fetch still completes.
    step("sq.start", 1, 0, 0, 8'h00, 0, 9'h000);
    step("sq.req", 0, 0, 0, 8'h00, 0, 9'h000);
    step("sq.wait", 0, 1, 1, 8'h44, 0, 9'h000);
    check("sq.seqErr_const", 32'(seqErr), 32'd1);
    step("sq.data", 0, 0, 0, 8'h00, 1, 9'h0C3);
    check("sq.opcode_const", 32'(instructions), 32'd3);

    // Randomized episodes with fresh memory images.
    for (int ep = 0; ep < 20; ep++) begin
      for (int a = 0; a < 256; a++) begin
        mem[a] = ($urandom_range(0, 31) == 0) ? 9'h1FF : 9'($urandom);
      end
      do_reset("rnd.rst");
      for (int c = 0; c < 150; c++) rand_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream stage of the multi-cycle control FSM.
- Owns the program counter and issues reads to the instruction memory. Latches the returned word into an instruction register.
- Presents the 3-bit opcode field (`instructions`) and operand bits to the control FSM and datapath.
- Advances the PC only on the control FSM's `nextIns` pulse, either sequentially or to a branch target. Detects the halt word.

Parameters:
- PC_W, 8, program counter width; instruction address space is 2^PC_W words.
- INSTR_W, 9, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-3], operand is bits [INSTR_W-4:0].
- HALT_WORD, 9'h1FF, instruction encoding that stops fetching.
- START_PC, 0, PC value after reset.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetN  in  1  reset; asynchronous, active-low.
- start  in  1  begin fetching from the current PC; honoured only in IDLE.
- nextIns  in  1  one-cycle advance pulse from the control FSM.
- branchTaken  in  1  qualifies nextIns; when 1, load branchTarget instead of pc+1.
- branchTarget  in  PC_W  absolute branch destination.
- imemReq  out  1  one-cycle read strobe to instruction memory.
- imemAddr  out  PC_W  read address; equals pc.
- imemData  in  INSTR_W  instruction word returned by memory.
- imemValid  in  1  imemData is valid this cycle.
- instructions  out  3  opcode of the held instruction (to control FSM).
- operand  out  INSTR_W-3  operand field of the held instruction.
- insValid  out  1  instruction register holds a valid, non-halt word.
- pc  out  PC_W  current program counter.
- done  out  1  halt word reached; sticky until reset.
- seqErr  out  1  sticky; nextIns arrived outside HOLD.

Behaviour:
- Reset (async, resetN=0) forces the following:
  - state=IDLE, pc=START_PC, IR=0.
  - imemReq=0, insValid=0, done=0, seqErr=0.
  - instructions=0, operand=0.
- Deassertion of resetN takes effect at the next clock edge.
- State machine (enum in package): IDLE, REQ, WAIT, HOLD, HALTED.
  - IDLE: start=1 -> REQ. Other inputs ignored; nextIns here sets seqErr.
  - REQ: imemReq=1 and imemAddr=pc for exactly one cycle -> WAIT.
  - WAIT: imemReq=0; hold until imemValid=1.
    - imemData==HALT_WORD: go to HALTED, set done=1, leave insValid=0.
    - Otherwise: IR<=imemData, then go to HOLD with insValid=1 from the next cycle.
  - HOLD: instructions=IR[INSTR_W-1:INSTR_W-3] and operand=IR low bits, held stable.
    - On nextIns=1:
      - pc <= branchTaken ? branchTarget : pc+1.
      - insValid <= 0; go to REQ.
  - HALTED: terminal; only reset exits. nextIns is ignored and does not set seqErr.
- Latency:
  - start to imemReq: 1 cycle.
  - imemValid to insValid=1: 1 cycle.
  - nextIns to next imemReq: 1 cycle, with the new pc already on imemAddr.
- imemValid arriving in any state other than WAIT is ignored; IR is unchanged.
- nextIns in REQ or WAIT:
  - Sets seqErr.
  - No PC change and no state change.
  - The fetch in flight completes normally.
- PC arithmetic is modulo 2^PC_W: pc=2^PC_W-1 with a sequential advance wraps to 0.
- branchTarget is used only when branchTaken and nextIns are both 1. branchTaken without nextIns has no effect.
- branchTarget==pc is legal (self-loop) and refetches the same address.
- Reset mid-fetch (WAIT): the outstanding response is discarded because the FSM is in IDLE when it arrives.
- aluOp/control timing: `instructions` must not change while insValid=1. It changes only after nextIns has been consumed.

Decomposition:
- Shared package `definitions` holds:
  - the fetch state enum (IDLE/REQ/WAIT/HOLD/HALTED);
  - INSTR_W, PC_W defaults and the HALT_WORD constant;
  - the existing opcode constants (ADD, XOR, AND, RSL, MOV, LD, ST, ...), extended with any branch opcode.
- Sub-module `program_counter`:
  - Inputs: clock, resetN, load, inc, target.
  - Output: PC_W-bit register.
  - Reset to START_PC, wrap-around increment, load has priority over inc.

Test Plan:
- Reset then start; memory returns 9'h041 at addr 0 after 2 cycles.
  - Required: imemReq/imemAddr=0 one cycle after start.
  - Required: instructions=3'b001, operand=6'h01, insValid=1 one cycle after imemValid.
- In HOLD, nextIns with branchTaken=0 and pc=5.
  - Required: pc=6 next cycle, insValid=0, imemReq=1 with imemAddr=6.
- In HOLD, nextIns with branchTaken=1 and branchTarget=8'h20.
  - Required: pc=8'h20, fetch issued at 8'h20.
  - Separately: branchTaken=1 without nextIns leaves pc unchanged.
- pc=8'hFF, sequential nextIns.
  - Required: pc=8'h00, imemAddr=0.
- Memory returns 9'h1FF.
  - Required: done=1, insValid=0, no further imemReq.
  - Required: a subsequent nextIns leaves seqErr=0.
- Drop resetN low during WAIT, release it, then assert imemValid.
  - Required: outputs at reset values, IR=0, seqErr=0, no state change until start.
- nextIns during WAIT.
  - Required: seqErr=1 (sticky), pc unchanged, fetch completes normally.
